pc_fetch_sequencer: RTL

- Sequences the program counter and the instruction-memory fetch handshake for the MIPS core.
- Selects the next PC from sequential, branch, jump/jal and jr sources, in priority order.
- Commits the next PC only when a fetched instruction is accepted. Honours pipeline stall and halt.
- Produces the jal link write and a saturating redirect counter for debug.

---
 rtl/pc_fetch_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer and instruction-fetch handshake for the MIPS core.
// Chooses the next PC in priority order and commits it only when a fetched instruction is accepted.
module pc_fetch_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 1,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic            jal,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic            instr_valid,
    output logic            link_we,
    output logic [PC_W-1:0] link_addr,
    output logic [1:0]      state_o,
    output logic            imem_err,
    output logic [15:0]     redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP     = PC_W'(PC_INC);
    localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT);

    state_t          state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] next_pc;
    logic            redirect;
    logic            commit;
    logic [7:0]      wait_cnt, wait_cnt_n, wait_inc;
    logic            imem_err_n;
    logic [15:0]     redirect_cnt_n;
    logic            link_we_n;
    logic [PC_W-1:0] link_addr_n;

    // Handshake decode and next-PC source selection (jr > jump/jal > branch > sequential)
    always_comb begin
        imem_req    = (state == ST_FETCH) || (state == ST_WAIT);
        instr_valid = imem_req & imem_ready;
        commit      = instr_valid & ~stall;
        seq_pc      = pc + PC_STEP;
        wait_inc    = wait_cnt + 8'd1;
        next_pc     = seq_pc;
        redirect    = 1'b0;
        if (jr) begin
            next_pc  = jr_target;
            redirect = 1'b1;
        end else if (jump || jal) begin
            next_pc  = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end
    end

    // Next-state logic; a stalled instruction is re-presented with control inputs ignored
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        wait_cnt_n     = wait_cnt;
        imem_err_n     = imem_err;
        redirect_cnt_n = redirect_cnt;
        link_we_n      = 1'b0;
        link_addr_n    = link_addr;
        case (state)
            ST_BOOT: begin
                state_n = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                if (commit) begin
                    wait_cnt_n = 8'd0;
                    if (halt) begin
                        state_n = ST_HALTED;
                    end else begin
                        state_n = ST_FETCH;
                        pc_n    = next_pc;
                        if (redirect && (redirect_cnt != 16'hFFFF))
                            redirect_cnt_n = redirect_cnt + 16'd1;
                        if (jal && !jr) begin
                            link_we_n   = 1'b1;
                            link_addr_n = seq_pc;
                        end
                    end
                end else if (instr_valid) begin
                    state_n    = ST_FETCH;
                    wait_cnt_n = 8'd0;
                end else begin
                    wait_cnt_n = wait_inc;
                    if (wait_inc >= TIMEOUT_CNT) begin
                        imem_err_n = 1'b1;
                        state_n    = ST_HALTED;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            default: begin
                state_n = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            wait_cnt     <= 8'd0;
            imem_err     <= 1'b0;
            redirect_cnt <= 16'd0;
            link_we      <= 1'b0;
            link_addr    <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            wait_cnt     <= wait_cnt_n;
            imem_err     <= imem_err_n;
            redirect_cnt <= redirect_cnt_n;
            link_we      <= link_we_n;
            link_addr    <= link_addr_n;
        end
    end

    assign state_o = state;

endmodule
